// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with advance/bubble/hold stall protocol, flush,
// sticky stall-protocol error flag and saturating bubble/hold counters.
module pipe_stage_reg #(
   parameter int                DATA_W   = 64,
   parameter int                STALL_W  = 6,
   parameter int                STAGE    = 2,   // legal range 0..STALL_W-2
   parameter int                CNT_W    = 16,
   parameter logic [DATA_W-1:0] NOP_DATA = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               clr_cnt,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_valid,
   output logic [CNT_W-1:0]   bubble_cnt,
   output logic [CNT_W-1:0]   hold_cnt,
   output logic               stall_err
);

   typedef enum logic [2:0] {
      ACT_LOAD,
      ACT_FLUSH,
      ACT_BUBBLE,
      ACT_HOLD,
      ACT_ILLEGAL
   } act_e;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              w_up;
   logic              w_dn;
   act_e              w_act;
   logic              w_unused_stall;

   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic [CNT_W-1:0]  r_bubble_cnt;
   logic [CNT_W-1:0]  r_hold_cnt;
   logic              r_stall_err;

   assign w_up           = stall[STAGE];
   assign w_dn           = stall[STAGE+1];
   // Stall bits belonging to other stages play no part in this register.
   assign w_unused_stall = ^stall;

   // NOTE: give w_act a default before any branch so no path leaves it unassigned (no latch).
   always_comb begin
      w_act = ACT_LOAD;
      if (flush) begin
         w_act = ACT_FLUSH;
      end else begin
         case ({w_up, w_dn})
            2'b10:   w_act = ACT_BUBBLE;
            2'b11:   w_act = ACT_HOLD;
            2'b01:   w_act = ACT_ILLEGAL;
            default: w_act = ACT_LOAD;
         endcase
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data  <= NOP_DATA;
         r_valid <= 1'b0;
      end else begin
         case (w_act)
            ACT_FLUSH, ACT_BUBBLE: begin
               r_data  <= NOP_DATA;
               r_valid <= 1'b0;
            end
            ACT_LOAD: begin
               r_data  <= in_valid ? in_data : NOP_DATA;
               r_valid <= in_valid;
            end
            // Hold and the illegal up=0/dn=1 case keep the register untouched.
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_err <= 1'b0;
      end else if (w_act == ACT_ILLEGAL) begin
         r_stall_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bubble_cnt <= '0;
         r_hold_cnt   <= '0;
      end else if (clr_cnt) begin
         r_bubble_cnt <= '0;
         r_hold_cnt   <= '0;
      end else begin
         if (w_act == ACT_BUBBLE && r_bubble_cnt != CNT_MAX) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
         end
         // Only a legal hold is counted; the illegal case is reported via stall_err.
         if (w_act == ACT_HOLD && r_hold_cnt != CNT_MAX) begin
            r_hold_cnt <= r_hold_cnt + CNT_ONE;
         end
      end
   end

   assign out_data   = r_data;
   assign out_valid  = r_valid;
   assign bubble_cnt = r_bubble_cnt;
   assign hold_cnt   = r_hold_cnt;
   assign stall_err  = r_stall_err;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: table of directed vectors plus
// hand-written sequences for async reset and counter saturation.
module tb_pipe_stage_reg;

   localparam logic [63:0] NOP = 64'h0BAD_0BAD_0BAD_0BAD;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic        clr_cnt;
   logic [63:0] in_data;
   logic        in_valid;

   logic [63:0] out_data;
   logic        out_valid;
   logic [15:0] bubble_cnt;
   logic [15:0] hold_cnt;
   logic        stall_err;

   logic [63:0] s_out_data;
   logic        s_out_valid;
   logic [1:0]  s_bubble_cnt;
   logic [1:0]  s_hold_cnt;
   logic        s_stall_err;

   int checks = 0;
   int errors = 0;

   pipe_stage_reg #(
      .DATA_W(64), .STALL_W(6), .STAGE(2), .CNT_W(16), .NOP_DATA(NOP)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
      .in_data(in_data), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid),
      .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt), .stall_err(stall_err)
   );

   pipe_stage_reg #(
      .DATA_W(64), .STALL_W(6), .STAGE(2), .CNT_W(2)
   ) dut_small (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
      .in_data(in_data), .in_valid(in_valid),
      .out_data(s_out_data), .out_valid(s_out_valid),
      .bubble_cnt(s_bubble_cnt), .hold_cnt(s_hold_cnt), .stall_err(s_stall_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  stall;
      logic        flush;
      logic        clr;
      logic [63:0] din;
      logic        vin;
      logic [63:0] edata;
      logic        evalid;
      logic [15:0] ebub;
      logic [15:0] ehold;
      logic        eerr;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] s, input logic f, input logic c,
                        input logic [63:0] d, input logic v);
      stall    = s;
      flush    = f;
      clr_cnt  = c;
      in_data  = d;
      in_valid = v;
   endtask

   initial begin
      rst = 1'b1;
      drive(6'b0, 1'b0, 1'b0, 64'h0, 1'b0);
      #2;
      check("rst data",   out_data,   NOP);
      check("rst valid",  out_valid,  1'b0);
      check("rst bubble", bubble_cnt, 16'd0);
      check("rst hold",   hold_cnt,   16'd0);
      check("rst err",    stall_err,  1'b0);
      @(negedge clk);
      rst = 1'b0;

      //               stall      fl    clr   din            vin   edata          ev    bub    hold   err
      vecs.push_back('{6'b000000, 1'b0, 1'b0, 64'hA5,        1'b1, 64'hA5,        1'b1, 16'd0, 16'd0, 1'b0}); // load
      vecs.push_back('{6'b000000, 1'b0, 1'b0, 64'h77,        1'b0, NOP,           1'b0, 16'd0, 16'd0, 1'b0}); // squash
      vecs.push_back('{6'b000000, 1'b0, 1'b0, 64'hA5,        1'b1, 64'hA5,        1'b1, 16'd0, 16'd0, 1'b0});
      vecs.push_back('{6'b001111, 1'b0, 1'b0, 64'h11,        1'b1, 64'hA5,        1'b1, 16'd0, 16'd1, 1'b0}); // hold x3
      vecs.push_back('{6'b001111, 1'b0, 1'b0, 64'h12,        1'b1, 64'hA5,        1'b1, 16'd0, 16'd2, 1'b0});
      vecs.push_back('{6'b001111, 1'b0, 1'b0, 64'h13,        1'b1, 64'hA5,        1'b1, 16'd0, 16'd3, 1'b0});
      vecs.push_back('{6'b000111, 1'b0, 1'b0, 64'h14,        1'b1, NOP,           1'b0, 16'd1, 16'd3, 1'b0}); // bubble
      vecs.push_back('{6'b000000, 1'b0, 1'b0, 64'h22,        1'b1, 64'h22,        1'b1, 16'd1, 16'd3, 1'b0});
      vecs.push_back('{6'b001111, 1'b1, 1'b0, 64'h23,        1'b1, NOP,           1'b0, 16'd1, 16'd3, 1'b0}); // flush over hold
      vecs.push_back('{6'b000000, 1'b0, 1'b0, 64'h33,        1'b1, 64'h33,        1'b1, 16'd1, 16'd3, 1'b0});
      vecs.push_back('{6'b001111, 1'b0, 1'b0, 64'h44,        1'b1, 64'h33,        1'b1, 16'd1, 16'd4, 1'b0});
      vecs.push_back('{6'b000000, 1'b0, 1'b0, 64'h44,        1'b1, 64'h44,        1'b1, 16'd1, 16'd4, 1'b0}); // hold -> load
      vecs.push_back('{6'b001111, 1'b0, 1'b0, 64'h45,        1'b1, 64'h44,        1'b1, 16'd1, 16'd5, 1'b0});
      vecs.push_back('{6'b000111, 1'b0, 1'b0, 64'h46,        1'b1, NOP,           1'b0, 16'd2, 16'd5, 1'b0}); // hold -> bubble
      vecs.push_back('{6'b110000, 1'b0, 1'b0, 64'h55,        1'b1, 64'h55,        1'b1, 16'd2, 16'd5, 1'b0}); // foreign bits
      vecs.push_back('{6'b000100, 1'b0, 1'b0, 64'h56,        1'b1, NOP,           1'b0, 16'd3, 16'd5, 1'b0});
      vecs.push_back('{6'b000100, 1'b0, 1'b1, 64'h57,        1'b1, NOP,           1'b0, 16'd0, 16'd0, 1'b0}); // clr + bubble
      vecs.push_back('{6'b000000, 1'b0, 1'b0, 64'h66,        1'b1, 64'h66,        1'b1, 16'd0, 16'd0, 1'b0});
      vecs.push_back('{6'b001000, 1'b0, 1'b0, 64'h77,        1'b1, 64'h66,        1'b1, 16'd0, 16'd0, 1'b1}); // illegal
      vecs.push_back('{6'b000000, 1'b0, 1'b0, 64'h77,        1'b1, 64'h77,        1'b1, 16'd0, 16'd0, 1'b1}); // sticky
      vecs.push_back('{6'b001111, 1'b0, 1'b1, 64'h78,        1'b1, 64'h77,        1'b1, 16'd0, 16'd0, 1'b1}); // clr + hold
      vecs.push_back('{6'b001000, 1'b1, 1'b0, 64'h79,        1'b1, NOP,           1'b0, 16'd0, 16'd0, 1'b1}); // flush over illegal

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].stall, vecs[i].flush, vecs[i].clr, vecs[i].din, vecs[i].vin);
         step();
         check($sformatf("v%0d data",   i), out_data,   vecs[i].edata);
         check($sformatf("v%0d valid",  i), out_valid,  vecs[i].evalid);
         check($sformatf("v%0d bubble", i), bubble_cnt, vecs[i].ebub);
         check($sformatf("v%0d hold",   i), hold_cnt,   vecs[i].ehold);
         check($sformatf("v%0d err",    i), stall_err,  vecs[i].eerr);
      end

      // Async reset in the middle of a hold, between clock edges.
      drive(6'b000000, 1'b0, 1'b0, 64'h1234, 1'b1);
      step();
      check("pre data", out_data, 64'h1234);
      drive(6'b001111, 1'b0, 1'b0, 64'h9999, 1'b1);
      step();
      step();
      check("pre hold", hold_cnt,  16'd2);
      check("pre err",  stall_err, 1'b1);
      #3;
      rst = 1'b1;
      #1;
      check("async data",   out_data,   NOP);
      check("async valid",  out_valid,  1'b0);
      check("async bubble", bubble_cnt, 16'd0);
      check("async hold",   hold_cnt,   16'd0);
      check("async err",    stall_err,  1'b0);
      @(negedge clk);
      rst = 1'b0;
      step();
      check("post-rst hold data", out_data, NOP);
      check("post-rst hold cnt",  hold_cnt, 16'd1);

      // Saturation of the 2-bit counters.
      rst = 1'b1;
      #1;
      rst = 1'b0;
      drive(6'b000111, 1'b0, 1'b0, 64'h0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         step();
         check($sformatf("sat bubble %0d", i), s_bubble_cnt, (i > 3) ? 2'd3 : 2'(i));
      end
      clr_cnt = 1'b1;
      step();
      check("sat clr bubble", s_bubble_cnt, 2'd0);
      clr_cnt = 1'b0;
      stall   = 6'b001111;
      for (int i = 1; i <= 5; i++) begin
         step();
         check($sformatf("sat hold %0d", i), s_hold_cnt, (i > 3) ? 2'd3 : 2'(i));
      end
      check("sat bubble kept", s_bubble_cnt, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
